// File: rtl/rf_pkg.sv
// ============================================================================
// Module   : rf_pkg
// Purpose  : Default constants and status-entry type for the dispatch regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_TAG_WIDTH  = 4;
  localparam int RF_SP_INDEX   = 2;
  localparam logic [RF_DATA_WIDTH-1:0] RF_SP_RESET = 32'h7FFF_EFFC;

  typedef struct packed {
    logic [RF_DATA_WIDTH-1:0] data;
    logic                     busy;
    logic [RF_TAG_WIDTH-1:0]  tag;
  } rf_entry_t;

endpackage

`default_nettype wire

// File: rtl/rf_status_entry.sv
// ============================================================================
// Module   : rf_status_entry
// Purpose  : One architectural register with busy bit and producer tag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_status_entry
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int TAG_WIDTH  = RF_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rst_data,
  input  logic                  disp_set,
  input  logic [TAG_WIDTH-1:0]  disp_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic [TAG_WIDTH-1:0]  tag
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  w_match;

  assign w_match = r_busy && cdb_valid && (r_tag == cdb_tag);

  // Data follows the CDB even when flush or a new reservation claims busy/tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= rst_data;
      r_busy <= 1'b0;
      r_tag  <= '0;
    end else begin
      if (w_match)
        r_data <= cdb_data;
      if (flush) begin
        r_busy <= 1'b0;
      end else if (disp_set) begin
        r_busy <= 1'b1;
        r_tag  <= disp_tag;
      end else if (w_match) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign data = r_data;
  assign busy = r_busy;
  assign tag  = r_tag;

endmodule

`default_nettype wire

// File: rtl/rf_status_regfile.sv
// ============================================================================
// Module   : rf_status_regfile
// Purpose  : Tomasulo status register file, two read ports with CDB bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_status_regfile
  import rf_pkg::*;
#(
  parameter int                  DATA_WIDTH = RF_DATA_WIDTH,
  parameter int                  ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int                  TAG_WIDTH  = RF_TAG_WIDTH,
  parameter int                  SP_INDEX   = RF_SP_INDEX,
  parameter logic [DATA_WIDTH-1:0] SP_RESET = RF_SP_RESET,
  parameter int                  ZERO_REG   = 1,
  localparam int                 NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic                  rs_busy,
  output logic [TAG_WIDTH-1:0]  rs_tag,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  rt_busy,
  output logic [TAG_WIDTH-1:0]  rt_tag,
  input  logic                  disp_en,
  input  logic [ADDR_WIDTH-1:0] disp_rd,
  input  logic [TAG_WIDTH-1:0]  disp_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [DATA_WIDTH-1:0] w_data [NUM_REGS];
  logic [TAG_WIDTH-1:0]  w_tag  [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign w_data[i] = '0;
      assign w_busy[i] = 1'b0;
      assign w_tag[i]  = '0;
    end else begin : g_entry
      localparam logic [DATA_WIDTH-1:0] c_rst_data = (i == SP_INDEX) ? SP_RESET : '0;
      logic w_disp_set;

      assign w_disp_set = disp_en && (disp_rd == ADDR_WIDTH'(i));

      rf_status_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
      ) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .rst_data  (c_rst_data),
        .disp_set  (w_disp_set),
        .disp_tag  (disp_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .flush     (flush),
        .data      (w_data[i]),
        .busy      (w_busy[i]),
        .tag       (w_tag[i])
      );
    end
  end

  // A busy operand whose producer broadcasts this cycle is served from the CDB.
  always_comb begin
    rs_data = w_data[rs_addr];
    rs_busy = w_busy[rs_addr];
    rs_tag  = w_tag[rs_addr];
    if (w_busy[rs_addr] && cdb_valid && (w_tag[rs_addr] == cdb_tag)) begin
      rs_busy = 1'b0;
      rs_data = cdb_data;
    end
  end

  always_comb begin
    rt_data = w_data[rt_addr];
    rt_busy = w_busy[rt_addr];
    rt_tag  = w_tag[rt_addr];
    if (w_busy[rt_addr] && cdb_valid && (w_tag[rt_addr] == cdb_tag)) begin
      rt_busy = 1'b0;
      rt_data = cdb_data;
    end
  end

  assign busy_vec = w_busy;

endmodule

`default_nettype wire
